// File: rtl/ins_encoder_pkg.sv
// Shared encoder types: request kinds, error codes and MIPS opcode/func constants.
// INS_ENCODER_PSEUDO_EN (see ins_encoder) enables the LI32 pseudo-instruction.
package ins_encoder_pkg;

   typedef enum logic [2:0] {
      KIND_R      = 3'd0,
      KIND_I      = 3'd1,
      KIND_REGIMM = 3'd2,
      KIND_J      = 3'd3,
      KIND_MFC0   = 3'd4,
      KIND_MTC0   = 3'd5,
      KIND_LI32   = 3'd6
   } EncKind_t;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_IMM_RANGE = 2'd1,
      ERR_SHAMT     = 2'd2,
      ERR_KIND      = 2'd3
   } ErrCode_t;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_COP0    = 6'h10;

   localparam logic [5:0] FUNC_SLL   = 6'h00;
   localparam logic [5:0] FUNC_SRL   = 6'h02;
   localparam logic [5:0] FUNC_SRA   = 6'h03;

   localparam logic [4:0] COP0_MF    = 5'd0;
   localparam logic [4:0] COP0_MT    = 5'd4;

   function automatic logic fitsSigned16(input logic [31:0] value);
      return (value[31:15] == '0) || (value[31:15] == '1);
   endfunction

   function automatic logic fitsUnsigned16(input logic [31:0] value);
      return value[31:16] == '0;
   endfunction

endpackage

// File: rtl/ins_encoder_packer.sv
// Combinational field packer: turns one encode request into an instruction word
// (or a LUI/ORI pair when INS_ENCODER_PSEUDO_EN is defined) plus an error code.
module ins_field_packer
   import ins_encoder_pkg::*;
(
   input  logic [2:0]  kind,
   input  logic [5:0]  code,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [31:0] imm,
   input  logic [25:0] target,
`ifdef INS_ENCODER_PSEUDO_EN
   output logic [31:0] word2,
   output logic        isPair,
`endif
   output logic [31:0] word,
   output ErrCode_t    errCode
);

   always_comb begin
      word    = '0;
      errCode = ERR_NONE;
`ifdef INS_ENCODER_PSEUDO_EN
      word2   = '0;
      isPair  = 1'b0;
`endif
      case (kind)
         KIND_R: begin
            word = {OP_SPECIAL, rs, rt, rd, shamt, code};
            if (shamt != 5'd0 && !(code inside {FUNC_SLL, FUNC_SRL, FUNC_SRA}))
               errCode = ERR_SHAMT;
         end
         KIND_I: begin
            word = {code, rs, rt, imm[15:0]};
            // Logical ops and LUI zero-extend, everything else sign-extends.
            if (code inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI}) begin
               if (!fitsUnsigned16(imm))
                  errCode = ERR_IMM_RANGE;
            end else if (!fitsSigned16(imm)) begin
               errCode = ERR_IMM_RANGE;
            end
         end
         KIND_REGIMM: begin
            word = {OP_REGIMM, rs, code[4:0], imm[15:0]};
            if (!fitsSigned16(imm))
               errCode = ERR_IMM_RANGE;
         end
         KIND_J: begin
            word = {code, target};
         end
         KIND_MFC0: begin
            word = {OP_COP0, COP0_MF, rt, rd, 8'b0, code[2:0]};
         end
         KIND_MTC0: begin
            word = {OP_COP0, COP0_MT, rt, rd, 8'b0, code[2:0]};
         end
`ifdef INS_ENCODER_PSEUDO_EN
         KIND_LI32: begin
            if (fitsSigned16(imm)) begin
               word = {OP_ADDIU, 5'd0, rt, imm[15:0]};
            end else begin
               word = {OP_LUI, 5'd0, rt, imm[31:16]};
               if (imm[15:0] != 16'd0) begin
                  word2  = {OP_ORI, rt, rt, imm[15:0]};
                  isPair = 1'b1;
               end
            end
         end
`endif
         default: begin
            errCode = ERR_KIND;
         end
      endcase
   end

endmodule

// File: rtl/ins_encoder.sv
// Sequential MIPS instruction encoder with valid/ready request and output streams.
// Define INS_ENCODER_PSEUDO_EN to enable LI32 expansion (adds the EXP2 state).
module ins_encoder
   import ins_encoder_pkg::*;
#(
   parameter int                ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_kind,
   input  logic [5:0]        req_code,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_shamt,
   input  logic [31:0]       req_imm,
   input  logic [25:0]       req_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_ins,
   output logic [ADDR_W-1:0] out_addr,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] addr_val,
   output logic              err_valid,
   output logic [1:0]        err_code
);

`ifdef INS_ENCODER_PSEUDO_EN
   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_EXP2} EncState_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_HOLD} EncState_t;
`endif

   EncState_t         stateReg;
   logic [31:0]       outInsReg;
   logic [ADDR_W-1:0] addrReg;
   logic              errValidReg;
   ErrCode_t          errCodeReg;
   logic [31:0]       packWord;
   ErrCode_t          packErr;
   logic              accept;
   logic              handshake;
`ifdef INS_ENCODER_PSEUDO_EN
   logic [31:0]       word2Reg;
   logic [31:0]       packWord2;
   logic              packPair;
`endif

   ins_field_packer packer (
      .kind    (req_kind),
      .code    (req_code),
      .rs      (req_rs),
      .rt      (req_rt),
      .rd      (req_rd),
      .shamt   (req_shamt),
      .imm     (req_imm),
      .target  (req_target),
`ifdef INS_ENCODER_PSEUDO_EN
      .word2   (packWord2),
      .isPair  (packPair),
`endif
      .word    (packWord),
      .errCode (packErr)
   );

   assign req_ready = (stateReg == ST_IDLE) | ((stateReg == ST_HOLD) & out_ready);
   assign out_valid = (stateReg != ST_IDLE);
   assign accept    = req_valid & req_ready;
   assign handshake = out_valid & out_ready;
   assign out_ins   = outInsReg;
   assign out_addr  = addrReg;
   assign err_valid = errValidReg;
   assign err_code  = errCodeReg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg    <= ST_IDLE;
         outInsReg   <= '0;
         addrReg     <= BASE_ADDR;
         errValidReg <= 1'b0;
         errCodeReg  <= ERR_NONE;
`ifdef INS_ENCODER_PSEUDO_EN
         word2Reg    <= '0;
`endif
      end else begin
         errValidReg <= 1'b0;
         errCodeReg  <= ERR_NONE;

         // A reload wins over the increment; the departing word keeps its old address.
         if (addr_load)
            addrReg <= addr_val;
         else if (handshake)
            addrReg <= addrReg + 1'b1;

         if (accept) begin
            if (packErr != ERR_NONE) begin
               errValidReg <= 1'b1;
               errCodeReg  <= packErr;
               stateReg    <= ST_IDLE;
            end else begin
               outInsReg <= packWord;
               stateReg  <= ST_HOLD;
`ifdef INS_ENCODER_PSEUDO_EN
               if (packPair) begin
                  word2Reg <= packWord2;
                  stateReg <= ST_EXP2;
               end
`endif
            end
         end else if (handshake) begin
            stateReg <= ST_IDLE;
`ifdef INS_ENCODER_PSEUDO_EN
            if (stateReg == ST_EXP2) begin
               outInsReg <= word2Reg;
               stateReg  <= ST_HOLD;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_ins_encoder.sv
// Table-driven bench for ins_encoder with an output-word scoreboard.
// Expectations for LI32 follow INS_ENCODER_PSEUDO_EN.
module tb_ins_encoder;
   import ins_encoder_pkg::*;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_kind;
   logic [5:0]        req_code;
   logic [4:0]        req_rs, req_rt, req_rd, req_shamt;
   logic [31:0]       req_imm;
   logic [25:0]       req_target;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_ins;
   logic [ADDR_W-1:0] out_addr;
   logic              addr_load;
   logic [ADDR_W-1:0] addr_val;
   logic              err_valid;
   logic [1:0]        err_code;

   ins_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(10'd0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_kind   (req_kind),
      .req_code   (req_code),
      .req_rs     (req_rs),
      .req_rt     (req_rt),
      .req_rd     (req_rd),
      .req_shamt  (req_shamt),
      .req_imm    (req_imm),
      .req_target (req_target),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ins    (out_ins),
      .out_addr   (out_addr),
      .addr_load  (addr_load),
      .addr_val   (addr_val),
      .err_valid  (err_valid),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  kind;
      logic [5:0]  code;
      logic [4:0]  rs, rt, rd, shamt;
      logic [31:0] imm;
      logic [25:0] target;
      logic [31:0] expIns;
      logic [31:0] expIns2;
      bit          expPair;
      logic [1:0]  expErr;
   } vec_t;

   typedef struct packed {
      logic [31:0]       ins;
      logic [ADDR_W-1:0] addr;
   } exp_t;

   vec_t              vecs[$];
   exp_t              expQ[$];
   exp_t              monExp;
   logic [ADDR_W-1:0] expAddr;
   int                checks   = 0;
   int                failures = 0;

   function automatic vec_t mk(string nm, logic [2:0] k, logic [5:0] c, logic [4:0] rs,
                               logic [4:0] rt, logic [4:0] rd, logic [4:0] sh,
                               logic [31:0] im, logic [25:0] tg, logic [31:0] e1,
                               logic [31:0] e2, bit pr, logic [1:0] er);
      vec_t v;
      v.name = nm; v.kind = k; v.code = c; v.rs = rs; v.rt = rt; v.rd = rd;
      v.shamt = sh; v.imm = im; v.target = tg; v.expIns = e1; v.expIns2 = e2;
      v.expPair = pr; v.expErr = er;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%h required=%h", nm, got, req);
      end
   endtask

   // Scoreboard: a handshake seen at the negedge completes on the following posedge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word got ins=%h addr=%h required none", out_ins, out_addr);
         end else begin
            monExp = expQ.pop_front();
            chk("word_ins", out_ins, monExp.ins);
            chk("word_addr", 32'(out_addr), 32'(monExp.addr));
            $display("word ins=%h addr=%h", out_ins, out_addr);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 one cycle after acceptance.
   task automatic doReq(input vec_t v);
      int n = 0;
      req_kind = v.kind; req_code = v.code; req_rs = v.rs; req_rt = v.rt;
      req_rd = v.rd; req_shamt = v.shamt; req_imm = v.imm; req_target = v.target;
      req_valid = 1'b1;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      if (v.expErr == ERR_NONE) begin
         expQ.push_back({v.expIns, expAddr});
         expAddr++;
         if (v.expPair) begin
            expQ.push_back({v.expIns2, expAddr});
            expAddr++;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({v.name, "_err_valid"}, 32'(err_valid), 32'(v.expErr != ERR_NONE));
      chk({v.name, "_err_code"}, 32'(err_code), 32'(v.expErr));
      $display("req %s kind=%0d err_code=%0d", v.name, v.kind, err_code);
   endtask

   task automatic drain();
      int n = 0;
      while (expQ.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_pending", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_kind = '0; req_code = '0; req_rs = '0;
      req_rt = '0; req_rd = '0; req_shamt = '0; req_imm = '0; req_target = '0;
      out_ready = 1'b1; addr_load = 1'b0; addr_val = '0; expAddr = '0;

      vecs.push_back(mk("add",     KIND_R,      6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0,        26'd0,     32'h00221820, 32'd0, 0, ERR_NONE));
      vecs.push_back(mk("addi_m1", KIND_I,      6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 32'hFFFFFFFF, 26'd0,     32'h2008FFFF, 32'd0, 0, ERR_NONE));
      vecs.push_back(mk("ori_big", KIND_I,      6'h0D, 5'd0, 5'd8, 5'd0, 5'd0, 32'h00010000, 26'd0,     32'd0,        32'd0, 0, ERR_IMM_RANGE));
      vecs.push_back(mk("mtc0",    KIND_MTC0,   6'h00, 5'd0, 5'd5, 5'd12,5'd0, 32'd0,        26'd0,     32'h40856000, 32'd0, 0, ERR_NONE));
      vecs.push_back(mk("mfc0",    KIND_MFC0,   6'h00, 5'd0, 5'd5, 5'd12,5'd0, 32'd0,        26'd0,     32'h40056000, 32'd0, 0, ERR_NONE));
      vecs.push_back(mk("sll",     KIND_R,      6'h00, 5'd0, 5'd1, 5'd2, 5'd4, 32'd0,        26'd0,     32'h00011100, 32'd0, 0, ERR_NONE));
      vecs.push_back(mk("add_sh",  KIND_R,      6'h20, 5'd1, 5'd2, 5'd3, 5'd1, 32'd0,        26'd0,     32'd0,        32'd0, 0, ERR_SHAMT));
      vecs.push_back(mk("j",       KIND_J,      6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0,        26'h100,   32'h08000100, 32'd0, 0, ERR_NONE));
      vecs.push_back(mk("bgez",    KIND_REGIMM, 6'h01, 5'd3, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 26'd0,     32'h0461FFFC, 32'd0, 0, ERR_NONE));
      vecs.push_back(mk("bgez_big",KIND_REGIMM, 6'h01, 5'd3, 5'd0, 5'd0, 5'd0, 32'd32768,    26'd0,     32'd0,        32'd0, 0, ERR_IMM_RANGE));
      vecs.push_back(mk("addi_min",KIND_I,      6'h08, 5'd2, 5'd1, 5'd0, 5'd0, 32'hFFFF8000, 26'd0,     32'h20418000, 32'd0, 0, ERR_NONE));
      vecs.push_back(mk("andi_max",KIND_I,      6'h0C, 5'd4, 5'd4, 5'd0, 5'd0, 32'd65535,    26'd0,     32'h3084FFFF, 32'd0, 0, ERR_NONE));
      vecs.push_back(mk("andi_neg",KIND_I,      6'h0C, 5'd4, 5'd4, 5'd0, 5'd0, 32'hFFFFFFFF, 26'd0,     32'd0,        32'd0, 0, ERR_IMM_RANGE));
      vecs.push_back(mk("kind7",   3'd7,        6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0,        26'd0,     32'd0,        32'd0, 0, ERR_KIND));
`ifdef INS_ENCODER_PSEUDO_EN
      vecs.push_back(mk("li32_pair",KIND_LI32,  6'h00, 5'd0, 5'd9, 5'd0, 5'd0, 32'h12345678, 26'd0,     32'h3C091234, 32'h35295678, 1, ERR_NONE));
      vecs.push_back(mk("li32_neg", KIND_LI32,  6'h00, 5'd0, 5'd3, 5'd0, 5'd0, 32'hFFFFFFFB, 26'd0,     32'h2403FFFB, 32'd0, 0, ERR_NONE));
      vecs.push_back(mk("li32_lui", KIND_LI32,  6'h00, 5'd0, 5'd2, 5'd0, 5'd0, 32'h00070000, 26'd0,     32'h3C020007, 32'd0, 0, ERR_NONE));
`else
      vecs.push_back(mk("li32_pair",KIND_LI32,  6'h00, 5'd0, 5'd9, 5'd0, 5'd0, 32'h12345678, 26'd0,     32'd0,        32'd0, 0, ERR_KIND));
`endif

      // Reset values, observed while reset is held.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_ins",   out_ins,        32'd0);
      chk("rst_out_addr",  32'(out_addr),  32'd0);
      chk("rst_err_valid", 32'(err_valid), 32'd0);
      chk("rst_err_code",  32'(err_code),  32'(ERR_NONE));
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);

      foreach (vecs[i]) doReq(vecs[i]);
      drain();

`ifdef INS_ENCODER_PSEUDO_EN
      // First LI32 word pending in EXP2: no request may be taken.
      doReq(vecs[14]);
      chk("exp2_req_ready", 32'(req_ready), 32'd0);
      chk("exp2_first_ins", out_ins, 32'h3C091234);
      drain();
`endif

      // Back-pressure: the pending word must hold still.
      out_ready = 1'b0;
      doReq(vecs[0]);
      for (int c = 0; c < 3; c++) begin
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_ins",   out_ins,        32'h00221820);
         chk("bp_out_addr",  32'(out_addr),  32'(expAddr - 1'b1));
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end

      // Reload coincident with the handshake, then wrap from 0x3FF to 0.
      addr_load = 1'b1;
      addr_val  = 10'h3FF;
      out_ready = 1'b1;
      @(posedge clk); #1;
      addr_load = 1'b0;
      expAddr   = 10'h3FF;
      chk("load_out_addr", 32'(out_addr), 32'h3FF);
      doReq(vecs[4]);
      doReq(vecs[7]);
      drain();

      // Reset with a word pending (EXP2 when expansion is built in).
      out_ready = 1'b0;
`ifdef INS_ENCODER_PSEUDO_EN
      doReq(vecs[14]);
`else
      doReq(vecs[1]);
`endif
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_addr",  32'(out_addr),  32'd0);
      expQ.delete();
      expAddr = 10'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("postrst_out_valid", 32'(out_valid), 32'd0);
      doReq(vecs[0]);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
